// File: rtl/dmem_access_unit.sv
// Memory-stage controller: issues one data-memory request at a time over a
// valid/ready handshake, returns zero-extended load data and stalls upstream.
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  is_mem_op_i,
  input  logic                  is_load_op_i,
  input  logic                  is_store_op_i,
  input  logic                  is_byte_op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  dmem_req_valid_o,
  input  logic                  dmem_req_ready_i,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_mask_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_resp_valid_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  stall_o,
  output logic                  load_data_valid_o,
  output logic [31:0]           load_data_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        misaligned_in;
  logic [3:0]  byte_mask_in;
  logic        load_q;
  logic        byte_q;
  logic        misaligned_q;
  logic [1:0]  lane_q;
  logic [31:0] load_fmt;

  assign accept        = (state == IDLE) && valid_i && is_mem_op_i;
  assign misaligned_in = !is_byte_op_i && (addr_i[1:0] != 2'b00);
  assign byte_mask_in  = 4'b0001 << addr_i[1:0];

  // Request fields are formatted once at accept so they stay stable in REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dmem_we_o    <= 1'b0;
      dmem_mask_o  <= 4'b0000;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= 32'h0;
      load_data_o  <= 32'h0;
      load_q       <= 1'b0;
      byte_q       <= 1'b0;
      misaligned_q <= 1'b0;
      lane_q       <= 2'b00;
    end else begin
      state <= state_next;
      if (accept) begin
        load_q       <= is_load_op_i && !is_store_op_i;
        dmem_we_o    <= !(is_load_op_i && !is_store_op_i);
        byte_q       <= is_byte_op_i;
        misaligned_q <= misaligned_in;
        lane_q       <= addr_i[1:0];
        dmem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        dmem_mask_o  <= is_byte_op_i ? byte_mask_in : 4'b1111;
        dmem_wdata_o <= is_byte_op_i ? {4{store_data_i[7:0]}} : store_data_i;
      end
      if ((state == WAIT) && dmem_resp_valid_i) begin
        load_data_o <= load_fmt;
      end
    end
  end

  always_comb begin
    load_fmt = dmem_rdata_i;
    if (byte_q) begin
      load_fmt = {24'h0, dmem_rdata_i[{lane_q, 3'b000} +: 8]};
    end
  end

  always_comb begin
    state_next        = state;
    dmem_req_valid_o  = 1'b0;
    load_data_valid_o = 1'b0;
    misaligned_o      = 1'b0;
    stall_o           = accept;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = misaligned_in ? DONE : REQ;
        end
      end
      REQ: begin
        dmem_req_valid_o = 1'b1;
        stall_o          = 1'b1;
        if (dmem_req_ready_i) begin
          state_next = load_q ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_resp_valid_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The slot still holds the retiring instruction, so valid_i is ignored.
        load_data_valid_o = load_q && !misaligned_q;
        misaligned_o      = misaligned_q;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed cases plus randomized ops against a
// transaction-level model of the expected requests, load results and stalls.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic        is_mem_op_i = 1'b0;
  logic        is_load_op_i = 1'b0;
  logic        is_store_op_i = 1'b0;
  logic        is_byte_op_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] store_data_i = 32'h0;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic        dmem_we_o;
  logic [3:0]  dmem_mask_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_resp_valid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        load_data_valid_o;
  logic [31:0] load_data_o;
  logic        misaligned_o;

  int testsRun = 0;
  int failCount = 0;

  bit          expReq;
  bit          expWe;
  logic [3:0]  expMask;
  logic [31:0] expAddr;
  logic [31:0] expWdata;
  bit          loadPending;
  logic [31:0] expLoad;
  logic [31:0] lastLoad = 32'h0;
  bit          expMis;
  int          loadPulses = 0;
  int          misPulses = 0;
  int          hsCount = 0;
  int          lastStall;
  bit          obsWe;
  logic [3:0]  obsMask;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;

  bit          manual = 1'b0;
  bit          manReady;
  bit          manResp;
  logic [31:0] manRdata = 32'h0;
  bit          autoReady;
  bit          autoResp;
  logic [31:0] autoRdata = 32'h0;
  bit          nextReady;
  bit          nextResp;
  logic [31:0] nextRdata = 32'h0;
  bit          rArmed;
  bit          rIsLoad;
  bit          rByte;
  bit          useFixed;
  int          rRdy, rRsp, rSeen, rLane, pendCnt;
  logic [31:0] pendData;
  logic [31:0] fixedRdata = 32'h0;

  assign dmem_req_ready_i  = manual ? manReady : autoReady;
  assign dmem_resp_valid_i = manual ? manResp : autoResp;
  assign dmem_rdata_i      = manual ? manRdata : autoRdata;

  dmem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_i           (valid_i),
    .is_mem_op_i       (is_mem_op_i),
    .is_load_op_i      (is_load_op_i),
    .is_store_op_i     (is_store_op_i),
    .is_byte_op_i      (is_byte_op_i),
    .addr_i            (addr_i),
    .store_data_i      (store_data_i),
    .dmem_req_valid_o  (dmem_req_valid_o),
    .dmem_req_ready_i  (dmem_req_ready_i),
    .dmem_we_o         (dmem_we_o),
    .dmem_mask_o       (dmem_mask_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_resp_valid_i (dmem_resp_valid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .stall_o           (stall_o),
    .load_data_valid_o (load_data_valid_o),
    .load_data_o       (load_data_o),
    .misaligned_o      (misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] loadResult(input logic [31:0] raw, input bit isByte, input int lane);
    if (isByte) return (raw >> (8 * lane)) & 32'hFF;
    return raw;
  endfunction

  // Memory responder: ready after a chosen number of REQ cycles, response a chosen
  // number of cycles after the handshake, random noise on ignored inputs otherwise.
  always @(negedge clk) begin
    if (rArmed && dmem_req_valid_o === 1'b1 && dmem_req_ready_i === 1'b1) begin
      rArmed = 1'b0;
      if (rIsLoad) begin
        pendData    = useFixed ? fixedRdata : $urandom;
        pendCnt     = rRsp;
        expLoad     = loadResult(pendData, rByte, rLane);
        loadPending = 1'b1;
      end
    end else if (rArmed && dmem_req_valid_o === 1'b1) begin
      rSeen++;
    end
    nextReady = rArmed ? (rSeen >= rRdy) : 1'($urandom_range(0, 1));
    if (pendCnt > 0) begin
      nextResp  = (pendCnt == 1);
      nextRdata = nextResp ? pendData : $urandom;
      pendCnt--;
    end else begin
      nextResp  = !rArmed && ($urandom_range(0, 3) == 0);
      nextRdata = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    autoReady = nextReady;
    autoResp  = nextResp;
    autoRdata = nextRdata;
  end

  // Compare process: request fields, load results and misaligned pulses every cycle.
  always @(negedge clk) begin
    if (dmem_req_valid_o === 1'b1) begin
      checkOutput("reqExpected", 32'(expReq), 32'd1);
      if (expReq) begin
        checkOutput("reqWe", 32'(dmem_we_o), 32'(expWe));
        checkOutput("reqMask", 32'(dmem_mask_o), 32'(expMask));
        checkOutput("reqAddr", dmem_addr_o, expAddr);
        if (expWe) checkOutput("reqWdata", dmem_wdata_o, expWdata);
      end
      if (dmem_req_ready_i === 1'b1) begin
        expReq   = 1'b0;
        obsWe    = dmem_we_o;
        obsMask  = dmem_mask_o;
        obsAddr  = dmem_addr_o;
        obsWdata = dmem_wdata_o;
        hsCount++;
      end
    end
    if (load_data_valid_o === 1'b1) begin
      checkOutput("loadExpected", 32'(loadPending), 32'd1);
      checkOutput("loadData", load_data_o, expLoad);
      lastLoad    = expLoad;
      loadPending = 1'b0;
      loadPulses++;
    end else begin
      checkOutput("loadHold", load_data_o, lastLoad);
    end
    if (misaligned_o === 1'b1) begin
      checkOutput("misExpected", 32'(expMis), 32'd1);
      expMis = 1'b0;
      misPulses++;
    end
  end

  task automatic applyStimulus(input bit v, input bit m, input bit ld, input bit st, input bit by,
                               input logic [31:0] a, input logic [31:0] d,
                               input int rdyDly, input int rspDly);
    int lane, expStall, stallCycles, cyc, loads0, mis0, hs0;
    bit live, mis, hasReq, isLoad;
    lane   = int'(a[1:0]);
    live   = v && m;
    mis    = live && !by && (lane != 0);
    hasReq = live && !mis;
    isLoad = ld && !st;
    if (!live) expStall = 0;
    else if (mis) expStall = 1;
    else expStall = 2 + rdyDly + (isLoad ? rspDly : 0);
    loads0 = loadPulses;
    mis0   = misPulses;
    hs0    = hsCount;
    @(posedge clk);
    #1;
    valid_i       = v;
    is_mem_op_i   = m;
    is_load_op_i  = ld;
    is_store_op_i = st;
    is_byte_op_i  = by;
    addr_i        = a;
    store_data_i  = d;
    if (hasReq) begin
      expReq   = 1'b1;
      expWe    = !isLoad;
      expAddr  = a & ~32'h3;
      expMask  = by ? 4'(1 << lane) : 4'hF;
      expWdata = by ? (d & 32'hFF) * 32'h01010101 : d;
      rIsLoad  = isLoad;
      rByte    = by;
      rLane    = lane;
      rRdy     = rdyDly;
      rRsp     = rspDly;
      rSeen    = 0;
      rArmed   = 1'b1;
    end
    expMis      = mis;
    stallCycles = 0;
    cyc         = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (stall_o === 1'b1) stallCycles++;
    end while (stall_o === 1'b1 && cyc < 60);
    #1;
    lastStall = stallCycles;
    checkOutput("opRetired", 32'(stall_o === 1'b0), 32'd1);
    checkOutput("stallCycles", stallCycles, expStall);
    checkOutput("loadPulses", loadPulses - loads0, (hasReq && isLoad) ? 1 : 0);
    checkOutput("misPulses", misPulses - mis0, mis ? 1 : 0);
    checkOutput("handshakes", hsCount - hs0, hasReq ? 1 : 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "ReqValid"}, 32'(dmem_req_valid_o), 32'd0);
    checkOutput({tag, "We"}, 32'(dmem_we_o), 32'd0);
    checkOutput({tag, "Mask"}, 32'(dmem_mask_o), 32'd0);
    checkOutput({tag, "Addr"}, dmem_addr_o, 32'd0);
    checkOutput({tag, "Wdata"}, dmem_wdata_o, 32'd0);
    checkOutput({tag, "LoadData"}, load_data_o, 32'd0);
    checkOutput({tag, "LoadValid"}, 32'(load_data_valid_o), 32'd0);
    checkOutput({tag, "Mis"}, 32'(misaligned_o), 32'd0);
    checkOutput({tag, "Stall"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    reset = 1'b0;

    applyStimulus(1, 1, 0, 1, 0, 32'h100, 32'hDEADBEEF, 0, 1);
    checkOutput("swStall", lastStall, 2);
    checkOutput("swWe", 32'(obsWe), 32'd1);
    checkOutput("swMask", 32'(obsMask), 32'hF);
    checkOutput("swAddr", obsAddr, 32'h100);
    checkOutput("swWdata", obsWdata, 32'hDEADBEEF);

    applyStimulus(1, 1, 0, 1, 1, 32'h103, 32'h000000A5, 0, 1);
    checkOutput("sbMask", 32'(obsMask), 32'h8);
    checkOutput("sbAddr", obsAddr, 32'h100);
    checkOutput("sbWdata", obsWdata, 32'hA5A5A5A5);

    useFixed   = 1'b1;
    fixedRdata = 32'h11223344;
    applyStimulus(1, 1, 1, 0, 1, 32'h202, 32'h0, 0, 1);
    checkOutput("lbuStall", lastStall, 3);
    checkOutput("lbuMask", 32'(obsMask), 32'h4);
    checkOutput("lbuData", load_data_o, 32'h00000022);

    fixedRdata = 32'h89ABCDEF;
    applyStimulus(1, 1, 1, 0, 0, 32'h300, 32'h0, 3, 4);
    checkOutput("lwSlowStall", lastStall, 9);
    checkOutput("lwSlowData", load_data_o, 32'h89ABCDEF);

    applyStimulus(1, 1, 1, 0, 0, 32'h302, 32'h0, 0, 1);
    checkOutput("misStall", lastStall, 1);
    checkOutput("misLoadHeld", load_data_o, 32'h89ABCDEF);

    // Reset while waiting for a load response, then deliver that response late.
    manual   = 1'b1;
    manReady = 1'b1;
    manResp  = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_load_op_i = 1'b1; is_store_op_i = 1'b0;
    is_byte_op_i = 1'b0; addr_i = 32'h300;
    expReq = 1'b1; expWe = 1'b0; expMask = 4'hF; expAddr = 32'h300;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    valid_i  = 1'b0;
    manReady = 1'b0;
    @(negedge clk);
    checkOutput("waitStall", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    lastLoad    = 32'h0;
    expReq      = 1'b0;
    loadPending = 1'b0;
    expMis      = 1'b0;
    @(negedge clk);
    checkResetOutputs("midRst");
    @(posedge clk);
    #1;
    reset    = 1'b0;
    manResp  = 1'b1;
    manRdata = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("lateRespValid", 32'(load_data_valid_o), 32'd0);
    checkOutput("lateRespData", load_data_o, 32'd0);
    @(posedge clk);
    #1;
    manResp = 1'b0;
    pendCnt = 0;
    rArmed  = 1'b0;
    manual  = 1'b0;
    fixedRdata = 32'h0BADF00D;
    applyStimulus(1, 1, 1, 0, 0, 32'h400, 32'h0, 1, 2);
    checkOutput("postRstLw", load_data_o, 32'h0BADF00D);

    applyStimulus(1, 0, 1, 1, 1, 32'h123, 32'h0, 0, 1);
    checkOutput("nonMemStall", lastStall, 0);
    applyStimulus(0, 1, 0, 1, 0, 32'h100, 32'h0, 0, 1);
    checkOutput("invalidStall", lastStall, 0);
    applyStimulus(1, 1, 1, 1, 0, 32'h500, 32'h12345678, 1, 2);
    checkOutput("bothIsStore", 32'(obsWe), 32'd1);

    useFixed = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bit v, m, ld, st, by;
      int k;
      logic [31:0] a;
      v  = ($urandom_range(0, 9) != 0);
      m  = ($urandom_range(0, 7) != 0);
      by = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 9));
      ld = (k < 4) || (k == 9);
      st = (k >= 4);
      if (!m) begin
        ld = 1'($urandom_range(0, 1));
        st = 1'($urandom_range(0, 1));
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      applyStimulus(v, m, ld, st, by, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory stage controller between the execute stage and the data-memory port. It consumes the decoded memory-class flags (load, store, memory-op, byte-op) together with the effective address and store data. It issues one request at a time to data memory over a valid/ready handshake and returns zero-extended load data to writeback. It also stalls the pipeline until the access completes.

## Interface
- ADDR_WIDTH, 32: byte-address width; data width is fixed at 32.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registered outputs.
- valid_i  in  1  memory-stage instruction slot holds a live instruction.
- is_mem_op_i  in  1  instruction is a load or store.
- is_load_op_i  in  1  instruction is LW or LBU.
- is_store_op_i  in  1  instruction is SW or SB.
- is_byte_op_i  in  1  instruction is LBU or SB; otherwise word access.
- addr_i  in  ADDR_WIDTH  effective byte address.
- store_data_i  in  32  store source operand; the low byte is used for SB.
- dmem_req_valid_o  out  1  request valid.
- dmem_req_ready_i  in  1  memory accepts the request.
- dmem_we_o  out  1  1 = write, 0 = read.
- dmem_mask_o  out  4  byte-lane enables; lane n = bits 8n+7:8n.
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2], 2'b00}.
- dmem_wdata_o  out  32  write data.
- dmem_resp_valid_i  in  1  read data valid; one pulse per read.
- dmem_rdata_i  in  32  read data.
- stall_o  out  1  hold the memory stage and everything upstream.
- load_data_valid_o  out  1  one-cycle pulse; load_data_o is fresh.
- load_data_o  out  32  load result; holds its value until the next load completes.
- misaligned_o  out  1  one-cycle pulse; a word access had addr_i[1:0] != 0 and was dropped.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Accept: the block is in IDLE with valid_i && is_mem_op_i set.
  - On accept it captures the address, store data, op type and byte flag into internal registers.
  - Word access with addr_i[1:0] != 0: go to DONE with the misaligned flag set; no memory request is issued.
  - Otherwise go to REQ.
- REQ: dmem_req_valid_o = 1.
  - Address, mask, we and wdata come from the captured registers and stay stable until the handshake.
  - Handshake = dmem_req_valid_o && dmem_req_ready_i.
  - On handshake, a store goes to DONE and a load goes to WAIT.
- WAIT: on dmem_resp_valid_i, capture the formatted data into load_data_o and go to DONE.
- DONE:
  - load_data_valid_o = 1 if the op was a completed load.
  - misaligned_o = 1 if the misaligned flag is set.
  - Always returns to IDLE on the next edge.
  - valid_i is ignored in DONE, because the slot still shows the retiring instruction.
- stall_o = (state != IDLE && state != DONE) || (state == IDLE && accept). It is combinational, so it is raised in the accept cycle itself.
- Mask and data formatting, little-endian, with b = captured addr[1:0]:
  - SW: mask 4'b1111; wdata = store data.
  - SB: mask = 4'b0001 << b; wdata = {4{store_data[7:0]}}.
  - LW: mask 4'b1111; result = rdata.
  - LBU: mask = 4'b0001 << b; result = {24'b0, rdata[8b+7:8b]}.
- valid_i with is_mem_op_i = 0 is ignored: no stall, no request.
- If is_load_op_i and is_store_op_i are both set (illegal), the block treats the op as a store.
- dmem_resp_valid_i outside WAIT is ignored.
- dmem_req_ready_i outside REQ is ignored.

## Timing
- Reset values:
  - state IDLE.
  - dmem_req_valid_o, dmem_we_o, load_data_valid_o, misaligned_o = 0.
  - dmem_mask_o, dmem_addr_o, dmem_wdata_o, load_data_o = 0.
  - stall_o = 0 unless an accept condition is present.
- Store, ready held high: accept at cycle 0 (stall 1); REQ with handshake at cycle 1 (stall 1); DONE at cycle 2 (stall 0); IDLE at cycle 3. The next memory op can be accepted no earlier than cycle 3.
- Load, ready high and response one cycle after the handshake: accept at c0, handshake at c1, response at c2, DONE at c3 with load_data_valid_o = 1. stall_o is high for c0–c2.
- Each cycle dmem_req_ready_i is low extends REQ by one cycle with the request held stable. Each cycle the response is late extends WAIT by one cycle. There is no timeout.
- Misaligned access: accept at c0 (stall 1), DONE at c1 with misaligned_o = 1 and dmem_req_valid_o never asserted.
- A response arriving in the same cycle as the request handshake is not supported; the memory must respond at the earliest one cycle after the handshake.
- Reset asserted in any state returns the block to IDLE immediately. A response pending from before reset is dropped.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready = 1 -> one request with we = 1, mask 1111, addr 0x100, wdata 0xDEADBEEF; stall high for exactly 2 cycles.
- SB addr 0x103, data 0x000000A5 -> mask 1000, addr 0x100, wdata 0xA5A5A5A5.
- LBU addr 0x202, rdata 0x11223344 returned 1 cycle after the handshake -> load_data_o = 0x00000022 with a load_data_valid_o pulse at c3.
- LW addr 0x300, ready low for 3 cycles, response delayed 4 cycles -> request fields stable throughout; stall is high until DONE; exactly one load_data_valid_o pulse.
- LW addr 0x302 -> misaligned_o pulses at c1; dmem_req_valid_o is never 1; load_data_o is unchanged.
- Assert reset while in WAIT, then deliver a response -> outputs are zero and the state is IDLE; the late response produces no load_data_valid_o; the next LW completes normally.
